// File: rtl/pulse_train_gen_pkg.sv
// Shared types and constants for the multi-channel pulse train generator.
package pulse_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_PERIOD = 2;

    // 1 Hz period / 50% duty at 156.25 MHz for the OTDR laser-pulse timing
    localparam int unsigned DEF_PERIOD_OTDR = 156250000;
    localparam int unsigned DEF_WIDTH_OTDR  = 78125000;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control, config and output bundle of pulse_train_gen; master drives, slave is the generator.
interface pulse_train_gen_if #(
    parameter int CNT_W  = 32,
    parameter int NUM_CH = 4
);
    logic                    en;
    logic                    mode;
    logic                    trig;
    logic                    cfg_valid;
    logic [CNT_W-1:0]        cfg_period;
    logic [CNT_W-1:0]        cfg_width;
    logic [NUM_CH*CNT_W-1:0] cfg_offset;
    logic [NUM_CH-1:0]       pulse_out;
    logic                    frame_start;
    logic                    busy;
    logic [CNT_W-1:0]        cnt;

    modport master (
        output en, mode, trig, cfg_valid, cfg_period, cfg_width, cfg_offset,
        input  pulse_out, frame_start, busy, cnt
    );

    modport slave (
        input  en, mode, trig, cfg_valid, cfg_period, cfg_width, cfg_offset,
        output pulse_out, frame_start, busy, cnt
    );
endinterface

// File: rtl/pulse_train_gen_chan.sv
// One output channel: phase of the shared count relative to this channel's offset,
// compared against the pulse width and registered.
module pulse_chan
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] offset,
    output logic             pulse
);
    logic [CNT_W:0] ph;
    logic           hit;

    // One extra bit so cnt + period cannot overflow before the offset is removed
    always_comb begin
        if (cnt >= offset) ph = {1'b0, cnt} - {1'b0, offset};
        else               ph = {1'b0, cnt} + {1'b0, period} - {1'b0, offset};
    end

    assign hit = run && (offset < period) && (ph < {1'b0, width});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse <= 1'b0;
        else        pulse <= hit;
    end
endmodule

// File: rtl/pulse_train_gen.sv
// NUM_CH phase-offset pulse trains from one period counter, with double-buffered
// period/width/offset config and continuous or one-shot operation.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          NUM_CH     = 4,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_OTDR,
    parameter int unsigned DEF_WIDTH  = DEF_WIDTH_OTDR
) (
    input logic              clk,
    input logic              rst_n,
    pulse_train_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_WIDTH  = CNT_W'(DEF_WIDTH);
    localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_e                       state;
    logic                         one_shot;
    logic [CNT_W-1:0]             cnt_q;
    logic [CNT_W-1:0]             shd_period, shd_width;
    logic [CNT_W-1:0]             act_period, act_width;
    logic [NUM_CH-1:0][CNT_W-1:0] shd_off, act_off;
    logic [NUM_CH-1:0]            pulse_q;
    logic                         frame_q;
    logic                         run, wrap, start;

    assign run   = (state == RUN);
    assign wrap  = run && (cnt_q == act_period - ONE);
    assign start = (state == IDLE) &&
                   ((!bus.mode && bus.en) || (bus.mode && bus.trig));

    // Shadow config: always accepted, only reaches the active set at start or wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_period <= RST_PERIOD;
            shd_width  <= RST_WIDTH;
            shd_off    <= '0;
        end else if (bus.cfg_valid) begin
            shd_period <= (bus.cfg_period < MIN_P) ? MIN_P : bus.cfg_period;
            shd_width  <= bus.cfg_width;
            shd_off    <= bus.cfg_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            one_shot   <= 1'b0;
            cnt_q      <= '0;
            act_period <= RST_PERIOD;
            act_width  <= RST_WIDTH;
            act_off    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state      <= RUN;
                        one_shot   <= bus.mode;
                        act_period <= shd_period;
                        act_width  <= shd_width;
                        act_off    <= shd_off;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        cnt_q      <= '0;
                        act_period <= shd_period;
                        act_width  <= shd_width;
                        act_off    <= shd_off;
                        // en is only looked at here, so a dropped en finishes the period
                        if (one_shot || !bus.en) state <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= 1'b0;
        else        frame_q <= run && (cnt_q == '0);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_chan #(.CNT_W(CNT_W)) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .run    (run),
            .cnt    (cnt_q),
            .period (act_period),
            .width  (act_width),
            .offset (act_off[i]),
            .pulse  (pulse_q[i])
        );
    end

    assign bus.pulse_out   = pulse_q;
    assign bus.frame_start = frame_q;
    assign bus.busy        = run;
    assign bus.cnt         = cnt_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen with CNT_W=8, NUM_CH=2 and small reset defaults.
module tb_pulse_train_gen;
    localparam int CW = 8;
    localparam int NC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pulse_train_gen_if #(.CNT_W(CW), .NUM_CH(NC)) bus ();

    pulse_train_gen #(
        .CNT_W(CW), .NUM_CH(NC), .DEF_PERIOD(20), .DEF_WIDTH(10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Called at a negedge; leaves a one-cycle cfg_valid pulse behind it
    task automatic cfg(input int p, input int w, input int o0, input int o1);
        bus.cfg_valid  = 1'b1;
        bus.cfg_period = 8'(p);
        bus.cfg_width  = 8'(w);
        bus.cfg_offset = {8'(o1), 8'(o0)};
        @(negedge clk);
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle busy=%b expected 0", name, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.pulse_out !== 2'b00 || bus.frame_start !== 1'b0 || bus.cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s_quiet pulse=%b frame=%b cnt=%0d expected 00/0/0",
                     name, bus.pulse_out, bus.frame_start, bus.cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.pulse_out !== 2'b00 || bus.frame_start !== 1'b0 ||
            bus.busy !== 1'b0 || bus.cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset pulse=%b frame=%b busy=%b cnt=%0d expected 00/0/0/0",
                     bus.pulse_out, bus.frame_start, bus.busy, bus.cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle busy=%b cnt=%0d expected 0/0", bus.busy, bus.cnt);
        end
    endtask

    // ch0 high for cnt 0..3, ch1 for 3..6, both reported one cycle late
    task automatic test_continuous();
        int c;
        logic [1:0] ep;
        logic ef;
        cfg(10, 4, 0, 3);
        bus.en = 1'b1;
        for (int k = 1; k <= 51; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cnt !== 8'((k-1) % 10) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL cont_cnt k=%0d cnt=%0d busy=%b expected %0d/1",
                         k, bus.cnt, bus.busy, (k-1) % 10);
            end
            ep = 2'b00; ef = 1'b0;
            if (k >= 2) begin
                c  = (k-2) % 10;
                ep = {(c >= 3 && c <= 6), (c <= 3)};
                ef = (c == 0);
            end
            checks++;
            if (bus.pulse_out !== ep || bus.frame_start !== ef) begin
                errors++;
                $display("FAIL cont_out k=%0d pulse=%b frame=%b expected %b/%b",
                         k, bus.pulse_out, bus.frame_start, ep, ef);
            end
        end
        bus.en = 1'b0;
        wait_idle("cont");
    endtask

    task automatic test_offset_wrap();
        int c;
        logic [1:0] ep;
        cfg(10, 4, 0, 8);
        bus.en = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            ep = 2'b00;
            if (k >= 2) begin
                c  = (k-2) % 10;
                ep = {(c >= 8 || c <= 1), (c <= 3)};
            end
            checks++;
            if (bus.pulse_out !== ep || bus.cnt !== 8'((k-1) % 10)) begin
                errors++;
                $display("FAIL wrap k=%0d pulse=%b cnt=%0d expected %b/%0d",
                         k, bus.pulse_out, bus.cnt, ep, (k-1) % 10);
            end
        end
        bus.en = 1'b0;
        wait_idle("wrap");
    endtask

    // Two one-shot runs; the first gets a stray trig mid-period
    task automatic test_oneshot();
        int c;
        logic [1:0] ep;
        logic ef, eb;
        logic [7:0] ec;
        cfg(10, 4, 0, 3);
        bus.mode = 1'b1;
        for (int r = 0; r < 2; r++) begin
            bus.trig = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                eb = (k <= 10);
                ec = (k <= 10) ? 8'(k-1) : 8'd0;
                ep = 2'b00; ef = 1'b0;
                if (k >= 2 && k <= 11) begin
                    c  = k - 2;
                    ep = {(c >= 3 && c <= 6), (c <= 3)};
                    ef = (c == 0);
                end
                checks++;
                if (bus.busy !== eb || bus.cnt !== ec ||
                    bus.pulse_out !== ep || bus.frame_start !== ef) begin
                    errors++;
                    $display("FAIL oneshot r=%0d k=%0d busy=%b cnt=%0d pulse=%b frame=%b expected %b/%0d/%b/%b",
                             r, k, bus.busy, bus.cnt, bus.pulse_out, bus.frame_start, eb, ec, ep, ef);
                end
                bus.trig = (r == 0 && k == 5);
            end
        end
        bus.mode = 1'b0;
    endtask

    // Period lengths: write 6 at cnt 4 -> next is 6; write 10 in a wrap cycle -> one
    // more 6 first; write 6 at cnt 9 of a 10-period -> one more 10 first.
    task automatic test_cfg_update();
        int pers[6];
        pers = '{10, 6, 6, 10, 10, 6};
        cfg(10, 4, 0, 3);
        bus.en = 1'b1;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < pers[p]; c++) begin
                @(negedge clk);
                checks++;
                if (bus.cnt !== 8'(c) || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL cfg_upd p=%0d c=%0d cnt=%0d busy=%b expected %0d/1",
                             p, c, bus.cnt, bus.busy, c);
                end
                bus.cfg_valid = 1'b0;
                if (p == 0 && c == 4) begin bus.cfg_valid = 1'b1; bus.cfg_period = 8'd6;  end
                if (p == 1 && c == 5) begin bus.cfg_valid = 1'b1; bus.cfg_period = 8'd10; end
                if (p == 3 && c == 9) begin bus.cfg_valid = 1'b1; bus.cfg_period = 8'd6;  end
                if (p == 5 && c == 0) bus.en = 1'b0;
            end
        end
        bus.cfg_valid = 1'b0;
        wait_idle("cfg_upd");
    endtask

    task automatic test_edge();
        logic [1:0] ep;
        logic ef;
        // Period 1 is stored as 2; width 0 keeps everything low
        cfg(1, 0, 0, 0);
        bus.en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            ef = (k >= 2) && ((k-2) % 2 == 0);
            checks++;
            if (bus.cnt !== 8'((k-1) % 2) || bus.pulse_out !== 2'b00 || bus.frame_start !== ef) begin
                errors++;
                $display("FAIL edge_min k=%0d cnt=%0d pulse=%b frame=%b expected %0d/00/%b",
                         k, bus.cnt, bus.pulse_out, bus.frame_start, (k-1) % 2, ef);
            end
        end
        bus.en = 1'b0;
        wait_idle("edge_min");
        // Width above period: ch0 always high; ch1 offset beyond period: forced low
        cfg(10, 12, 0, 11);
        bus.en = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            ep = (k >= 2) ? 2'b01 : 2'b00;
            checks++;
            if (bus.pulse_out !== ep) begin
                errors++;
                $display("FAIL edge_wide k=%0d pulse=%b expected %b", k, bus.pulse_out, ep);
            end
        end
        bus.en = 1'b0;
        wait_idle("edge_wide");
    endtask

    task automatic test_stop_reset();
        int c;
        logic [1:0] ep;
        logic ef, eb;
        logic [7:0] ec;
        cfg(10, 4, 0, 3);
        bus.en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            eb = (k <= 10);
            ec = (k <= 10) ? 8'(k-1) : 8'd0;
            ep = 2'b00;
            if (k >= 2 && k <= 11) begin
                c  = k - 2;
                ep = {(c >= 3 && c <= 6), (c <= 3)};
            end
            checks++;
            if (bus.busy !== eb || bus.cnt !== ec || bus.pulse_out !== ep) begin
                errors++;
                $display("FAIL stop k=%0d busy=%b cnt=%0d pulse=%b expected %b/%0d/%b",
                         k, bus.busy, bus.cnt, bus.pulse_out, eb, ec, ep);
            end
            if (k == 4) bus.en = 1'b0;
        end
        // Run again, then reset with cnt=5 and ch1 high
        bus.en = 1'b1;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cnt !== 8'd0 || bus.busy !== 1'b0 ||
            bus.pulse_out !== 2'b00 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid cnt=%0d busy=%b pulse=%b frame=%b expected 0/0/00/0",
                     bus.cnt, bus.busy, bus.pulse_out, bus.frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Defaults: period 20, width 10, offsets 0
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            ep = 2'b00; ef = 1'b0;
            if (k >= 2) begin
                c  = (k-2) % 20;
                ep = (c <= 9) ? 2'b11 : 2'b00;
                ef = (c == 0);
            end
            checks++;
            if (bus.cnt !== 8'((k-1) % 20) || bus.pulse_out !== ep || bus.frame_start !== ef) begin
                errors++;
                $display("FAIL rst_defaults k=%0d cnt=%0d pulse=%b frame=%b expected %0d/%b/%b",
                         k, bus.cnt, bus.pulse_out, bus.frame_start, (k-1) % 20, ep, ef);
            end
        end
        bus.en = 1'b0;
        wait_idle("rst_defaults");
    endtask

    initial begin
        bus.en         = 1'b0;
        bus.mode       = 1'b0;
        bus.trig       = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_width  = '0;
        bus.cfg_offset = '0;
        test_reset();
        test_continuous();
        test_offset_wrap();
        test_oneshot();
        test_cfg_update();
        test_edge();
        test_stop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
